// File: rtl/act_readout_sequencer.sv
// act_readout_sequencer
// Drains activations from the accelerator host read port: issues act_no read
// requests walking PE 0..NUM_PE-1 per activation address, buffers returned
// {index, value} words in a first-word-fall-through FIFO, and streams them
// downstream. A credit limit of FIFO_DEPTH (in-flight + buffered) guarantees
// that returned data never overflows the FIFO.
//
// Handshake semantics (all three ports): a beat transfers on the rising clock
// edge where valid and ready are both high; the valid side holds its payload
// stable until that edge and never waits on ready to raise valid.
//   request : read_en       / read_rdy
//   return  : read_data_vld / read_data_rdy
//   output  : out_vld       / out_rdy

module act_readout_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int RDATA_W    = 28,
  parameter int NUM_PE     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [11:0]        act_no,
  output logic               busy,
  output logic               done,
  output logic               idx_err,
  output logic               read_en,
  input  logic               read_rdy,
  output logic [ADDR_W-1:0]  read_addr,
  output logic               read_data_rdy,
  input  logic               read_data_vld,
  input  logic [RDATA_W-1:0] read_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [11:0]        out_idx,
  output logic [15:0]        out_act,
  output logic [1:0]         dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [5:0]  PE_LAST = 6'(NUM_PE - 1);
  localparam logic [CW:0] CREDIT_LIM = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] act_no_q, act_no_d;
  logic [11:0] issued_q, issued_d;
  logic [11:0] out_cnt_q, out_cnt_d;
  logic [11:0] exp_idx_q, exp_idx_d;
  logic [5:0]  pe_idx_q, pe_idx_d;
  logic [5:0]  act_addr_q, act_addr_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic        rd_en_q, rd_en_d;
  logic        idx_err_q, idx_err_d;

  logic [RDATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic          req_xfer;
  logic          rsp_acc;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW:0]   credit_sum;
  logic [RDATA_W-1:0] head;

  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign req_xfer   = rd_en_q && read_rdy;
  assign read_data_rdy = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && !fifo_full;
  assign rsp_acc    = read_data_vld && read_data_rdy;
  assign out_vld    = !fifo_empty;
  assign pop        = out_vld && out_rdy;
  assign head       = mem_q[rd_ptr_q];

  assign read_en   = rd_en_q;
  assign read_addr = ADDR_W'({pe_idx_q, 4'b0000, act_addr_q});
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign idx_err   = idx_err_q;
  assign out_idx   = out_vld ? head[27:16] : 12'd0;
  assign out_act   = out_vld ? head[15:0]  : 16'd0;
  assign dbg_state = state_q;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    if (rsp_acc && !pop) count_d = count_q + CW'(1);
    else if (!rsp_acc && pop) count_d = count_q - CW'(1);
  end

  // Next-state, counters, address walk, index check and request-valid generation.
  always_comb begin
    state_d    = state_q;
    act_no_d   = act_no_q;
    issued_d   = issued_q;
    out_cnt_d  = out_cnt_q;
    exp_idx_d  = exp_idx_q;
    pe_idx_d   = pe_idx_q;
    act_addr_d = act_addr_q;
    inflight_d = inflight_q;
    idx_err_d  = idx_err_q;
    rd_en_d    = 1'b0;
    credit_sum = '0;

    if (req_xfer) begin
      issued_d = issued_q + 12'd1;
      if (pe_idx_q == PE_LAST) begin
        pe_idx_d   = 6'd0;
        act_addr_d = act_addr_q + 6'd1;
      end else begin
        pe_idx_d = pe_idx_q + 6'd1;
      end
    end

    if (rsp_acc) begin
      exp_idx_d = exp_idx_q + 12'd1;
      if (read_data[27:16] != exp_idx_q) idx_err_d = 1'b1;
    end

    if (pop) out_cnt_d = out_cnt_q + 12'd1;

    // Simultaneous transfer and acceptance cancel out.
    if (req_xfer && !rsp_acc) inflight_d = inflight_q + CW'(1);
    else if (!req_xfer && rsp_acc) inflight_d = inflight_q - CW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          act_no_d   = act_no;
          issued_d   = 12'd0;
          out_cnt_d  = 12'd0;
          exp_idx_d  = 12'd0;
          pe_idx_d   = 6'd0;
          act_addr_d = 6'd0;
          inflight_d = '0;
          state_d    = (act_no == 12'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_xfer && (issued_q == act_no_q - 12'd1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (out_cnt_q == act_no_q - 12'd1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered request valid: raised only with credit left after this cycle,
    // so once high it stays high until it transfers.
    credit_sum = {1'b0, inflight_d} + {1'b0, count_d};
    rd_en_d = (state_d == S_ISSUE) && (issued_d < act_no_d) && (credit_sum < CREDIT_LIM);
  end

  // Control and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      act_no_q   <= 12'd0;
      issued_q   <= 12'd0;
      out_cnt_q  <= 12'd0;
      exp_idx_q  <= 12'd0;
      pe_idx_q   <= 6'd0;
      act_addr_q <= 6'd0;
      inflight_q <= '0;
      rd_en_q    <= 1'b0;
      idx_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_no_q   <= act_no_d;
      issued_q   <= issued_d;
      out_cnt_q  <= out_cnt_d;
      exp_idx_q  <= exp_idx_d;
      pe_idx_q   <= pe_idx_d;
      act_addr_q <= act_addr_d;
      inflight_q <= inflight_d;
      rd_en_q    <= rd_en_d;
      idx_err_q  <= idx_err_d;
    end
  end

  // Return FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (rsp_acc) begin
        mem_q[wr_ptr_q] <= read_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule
